// File: rtl/dsp_pkg.sv
// Shared types, config encodings and arithmetic helpers for the DDS voice sequencer.
package dsp_pkg;

    localparam int LUT_BITS_DEF = 9;
    localparam int OUT_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        LOOK = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam logic [1:0] CFG_FREQ  = 2'd0;
    localparam logic [1:0] CFG_PHASE = 2'd1;
    localparam logic [1:0] CFG_ACC   = 2'd2;

    // a + b clamped to the signed range of a w-bit word (w <= 31); never wraps.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] s, hi, lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/sine_rom.sv
// Full-wave sine table, 2^LUT_BITS x OUT_W, with a registered one-cycle read.
// Contents are round(A*sin(2*pi*k/2^LUT_BITS)), A = 2^(OUT_W-1)-1, built at
// elaboration from a quarter wave with fixed-point Taylor series (Q60).
module sine_rom
    import dsp_pkg::*;
#(
    parameter int LUT_BITS = LUT_BITS_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic                clk,
    input  logic [LUT_BITS-1:0] addr_i,
    output logic [OUT_W-1:0]    data_o
);

    localparam int DEPTH = 1 << LUT_BITS;
    localparam int QTR   = DEPTH / 4;
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;
    localparam logic signed [127:0] AMP    = 128'((1 << (OUT_W - 1)) - 1);

    // Quarter-wave symmetry folds k onto [0, QTR]; the second half is negated.
    function automatic logic [OUT_W-1:0] sine_entry(input int k);
        int j;
        logic neg;
        logic signed [127:0] x, x2, term, acc, den, r;
        neg = (k >= 2 * QTR);
        j   = neg ? k - 2 * QTR : k;
        if (j > QTR) j = 2 * QTR - j;
        x    = (PI_Q60 * 128'(j)) >>> (LUT_BITS - 1);
        x2   = (x * x) >>> 60;
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            den  = 128'((2 * n) * (2 * n + 1));
            term = -((term * x2) >>> 60) / den;
            acc  = acc + term;
        end
        r = (acc * AMP + (128'sd1 <<< 59)) >>> 60;
        return neg ? OUT_W'(-r) : OUT_W'(r);
    endfunction

    logic [OUT_W-1:0] lut [DEPTH];
    logic [OUT_W-1:0] data_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_lut
        assign lut[k] = sine_entry(k);
    end

    // Registered read: data for the address presented this cycle appears next cycle.
    always_ff @(posedge clk) begin
        data_q <= lut[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_voice_sequencer.sv
// Time-multiplexed multi-voice DDS: one phase adder and one sine ROM are shared
// across NUM_VOICES voices; each sample strobe walks all voices and emits a
// saturated mix.
module dds_voice_sequencer
    import dsp_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 32,
    parameter int LUT_BITS   = LUT_BITS_DEF,
    parameter int OUT_W      = OUT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_en,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_addr,
    input  logic [1:0]                    cfg_sel,
    input  logic [ACC_W-1:0]              cfg_data,
    output logic [OUT_W-1:0]              mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int SW = OUT_W + VW + 1;

    logic [ACC_W-1:0]     freq_q  [NUM_VOICES];
    logic [ACC_W-1:0]     phase_q [NUM_VOICES];
    logic [ACC_W-1:0]     acc_q   [NUM_VOICES];

    state_e               state_q;
    logic [VW-1:0]        v_q;
    logic signed [SW-1:0] sum_q;
    logic                 en_q;
    logic [OUT_W-1:0]     mix_q;
    logic                 mix_valid_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic [ACC_W-1:0]     ph_sum;
    logic [LUT_BITS-1:0]  rom_addr;
    logic [OUT_W-1:0]     rom_data;
    logic signed [31:0]   sum_ext;
    logic signed [31:0]   sat_full;
    logic                 unused_bits;

    // Phase of the current voice uses the pre-increment accumulator; the ROM
    // registers this address at the end of ADDR so data is ready in LOOK.
    always_comb begin
        ph_sum   = acc_q[v_q] + phase_q[v_q];
        rom_addr = ph_sum[ACC_W-1 -: LUT_BITS];
    end

    sine_rom #(
        .LUT_BITS (LUT_BITS),
        .OUT_W    (OUT_W)
    ) u_rom (
        .clk    (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Widen the running sum and clamp it to the output range.
    always_comb begin
        sum_ext  = {{(32 - SW){sum_q[SW-1]}}, sum_q};
        sat_full = sat_add(sum_ext, 32'sd0, OUT_W);
    end

    assign unused_bits = ^{ph_sum[ACC_W-LUT_BITS-1:0], sat_full[31:OUT_W]};

    // Voice registers: ADDR advances the active voice; a config write issued in
    // the same cycle is scheduled later so an accumulator load takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i]  <= '0;
                phase_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            if (state_q == ADDR && voice_en[v_q])
                acc_q[v_q] <= acc_q[v_q] + freq_q[v_q];
            if (cfg_we) begin
                case (cfg_sel)
                    CFG_FREQ:  freq_q[cfg_addr]  <= cfg_data;
                    CFG_PHASE: phase_q[cfg_addr] <= cfg_data;
                    CFG_ACC:   acc_q[cfg_addr]   <= cfg_data;
                    default: ;
                endcase
            end
        end
    end

    // Sequencer FSM: IDLE -> (ADDR, LOOK) per voice -> OUT -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            v_q         <= '0;
            sum_q       <= '0;
            en_q        <= 1'b0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;
            if (sample_en && state_q != IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (sample_en) begin
                        state_q <= ADDR;
                        v_q     <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ADDR: begin
                    en_q    <= voice_en[v_q];
                    state_q <= LOOK;
                end
                LOOK: begin
                    if (en_q)
                        sum_q <= sum_q + {{(SW - OUT_W){rom_data[OUT_W-1]}}, rom_data};
                    if (v_q == VW'(NUM_VOICES - 1)) begin
                        state_q <= OUT;
                    end else begin
                        v_q     <= v_q + VW'(1);
                        state_q <= ADDR;
                    end
                end
                OUT: begin
                    mix_q       <= sat_full[OUT_W-1:0];
                    mix_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dds_voice_sequencer.sv
// Directed bench for dds_voice_sequencer with a scoreboard of expected mixes.
module tb_dds_voice_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [3:0]  voice_en = 4'h0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_data = 32'd0;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int nvec = 0;
    int nerr = 0;
    int exp_q[$];

    dds_voice_sequencer #(
        .NUM_VOICES (4),
        .ACC_W      (32),
        .LUT_BITS   (9),
        .OUT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .voice_en  (voice_en),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .mix_out   (mix_out),
        .mix_valid (mix_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic int rom_ref(input int k);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 512.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [1:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mix_valid) seen = 1'b1;
        end
        chk("mix_valid_seen", int'(seen), 1);
    endtask

    task automatic run_sample(input int expv);
        exp_q.push_back(expv);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        wait_done();
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mix_valid) cnt++;
        end
    endtask

    // Scoreboard: every mix_valid pops the oldest expected mix.
    always @(negedge clk) begin
        if (!rst && mix_valid) begin
            chk("mix_valid_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("mix_out", int'($signed(mix_out)), exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        bit seen;

        // Reset state
        repeat (3) tick();
        chk("rst_mix_out", int'(mix_out), 0);
        chk("rst_mix_valid", int'(mix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        tick();

        // All-zero words, all voices: exact latency and pulse width
        voice_en = 4'hF;
        exp_q.push_back(0);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("busy_after_strobe", int'(busy), 1);
        n = 0; seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick();
            if (mix_valid) begin seen = 1'b1; n = i; end
        end
        chk("latency_edges", n, 9);
        tick();
        chk("mix_valid_one_cycle", int'(mix_valid), 0);
        chk("busy_back_idle", int'(busy), 0);
        chk("overrun_clear", int'(overrun), 0);

        // Phase offsets and saturation
        voice_en = 4'b0001;
        cfg(2'd1, 2'd0, 32'h4000_0000);
        run_sample(32767);
        voice_en = 4'b0011;
        cfg(2'd1, 2'd1, 32'h4000_0000);
        run_sample(32767);
        cfg(2'd1, 2'd0, 32'hC000_0000);
        cfg(2'd1, 2'd1, 32'hC000_0000);
        run_sample(-32768);

        // Reserved select must not change anything
        cfg(2'd3, 2'd0, 32'h0000_0000);
        run_sample(-32768);

        // Frequency sweep over a full table turn plus wrap
        cfg(2'd1, 2'd0, 32'h0);
        cfg(2'd1, 2'd1, 32'h0);
        voice_en = 4'b0001;
        cfg(2'd0, 2'd0, 32'h0080_0000);
        for (int k = 0; k <= 512; k++) run_sample(rom_ref(k % 512));

        // Accumulator load in voice0's ADDR cycle beats the increment
        exp_q.push_back(rom_ref(1));
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        cfg(2'd2, 2'd0, 32'h0);
        wait_done();
        run_sample(rom_ref(0));
        run_sample(rom_ref(1));

        // Disabled voices contribute zero and hold phase
        voice_en = 4'b0000;
        for (int k = 0; k < 5; k++) run_sample(0);
        voice_en = 4'b0001;
        run_sample(rom_ref(2));

        // Overrun: a second strobe while busy is ignored but flagged
        chk("overrun_before", int'(overrun), 0);
        exp_q.push_back(rom_ref(3));
        sample_en = 1'b1; tick();
        sample_en = 1'b0; tick(); tick();
        sample_en = 1'b1; tick();
        sample_en = 1'b0;
        count_valid(20, cnt);
        chk("overrun_single_valid", cnt, 1);
        chk("overrun_set", int'(overrun), 1);
        run_sample(rom_ref(4));
        chk("overrun_sticky", int'(overrun), 1);

        // Reset mid-computation aborts cleanly
        sample_en = 1'b1; tick();
        sample_en = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_mix_valid", int'(mix_valid), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_mix_out", int'(mix_out), 0);
        rst = 1'b0;
        count_valid(15, cnt);
        chk("abort_no_valid", cnt, 0);

        // Words were cleared by reset: only voice2's new phase contributes
        voice_en = 4'hF;
        cfg(2'd1, 2'd2, 32'hC000_0000);
        run_sample(-32767);

        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
